// File: rtl/station_sched_pkg.sv
// -----------------------------------------------------------------------------
// sched_pkg
// Shared widths and flattened-bus slice helpers for the station issue
// scheduler (station_sched and its interface).
//
// Contents:
//   REG_W        architectural register address width (8 registers)
//   DADR_W       destination address width; the top bit flags a write
//   WB_CNT_W     width of one scoreboard countdown
//   DADR_WR_BIT  index of the write flag inside a destination address
//   MAX_ST       largest supported station count; the slice helpers take
//                buses zero-extended to this many stations
// -----------------------------------------------------------------------------
package sched_pkg;

  localparam int REG_W       = 3;
  localparam int DADR_W      = 4;
  localparam int WB_CNT_W    = 2;
  localparam int DADR_WR_BIT = 3;
  localparam int N_REGS      = 1 << REG_W;
  localparam int MAX_ST      = 8;

  // Register address of station idx from a flattened per-station bus.
  function automatic logic [REG_W-1:0] reg_slice(
    input logic [MAX_ST*REG_W-1:0] flat,
    input int                      idx
  );
    return flat[idx*REG_W +: REG_W];
  endfunction

  // Destination/lock field of station idx from a flattened per-station bus.
  function automatic logic [DADR_W-1:0] dadr_slice(
    input logic [MAX_ST*DADR_W-1:0] flat,
    input int                       idx
  );
    return flat[idx*DADR_W +: DADR_W];
  endfunction

endpackage

// File: rtl/station_sched_if.sv
// -----------------------------------------------------------------------------
// station_sched_if
// Bundle between the reservation stations / execute stage and the issue
// scheduler.
//
// Parameter: N_ST  number of stations
// Station -> scheduler: st_alloc, st_ready, st_will_cmp, st_a_adr, st_b_adr,
//   st_d_adr, st_bypass_b, st_ld, st_st, st_lock_ld, st_lock_wr (flattened,
//   station 0 at the LSBs), lsu_wb, ex_stall
// Scheduler -> stations: sched_ack (one-hot grant)
// Scheduler -> issue stage: iss_valid, iss_sel, iss_a_adr, iss_b_adr,
//   iss_d_adr, iss_ld, iss_st
// Modports: master = stations/execute side, slave = scheduler.
// -----------------------------------------------------------------------------
interface station_sched_if #(
  parameter int N_ST = 4
);
  import sched_pkg::*;

  localparam int SEL_W = (N_ST > 1) ? $clog2(N_ST) : 1;

  logic [N_ST-1:0]        st_alloc;
  logic [N_ST-1:0]        st_ready;
  logic [N_ST-1:0]        st_will_cmp;
  logic [REG_W*N_ST-1:0]  st_a_adr;
  logic [REG_W*N_ST-1:0]  st_b_adr;
  logic [DADR_W*N_ST-1:0] st_d_adr;
  logic [N_ST-1:0]        st_bypass_b;
  logic [N_ST-1:0]        st_ld;
  logic [N_ST-1:0]        st_st;
  logic [N_ST-1:0]        st_lock_ld;
  logic [DADR_W*N_ST-1:0] st_lock_wr;
  logic                   lsu_wb;
  logic                   ex_stall;

  logic [N_ST-1:0]        sched_ack;

  logic                   iss_valid;
  logic [SEL_W-1:0]       iss_sel;
  logic [REG_W-1:0]       iss_a_adr;
  logic [REG_W-1:0]       iss_b_adr;
  logic [DADR_W-1:0]      iss_d_adr;
  logic                   iss_ld;
  logic                   iss_st;

  modport master (
    output st_alloc, st_ready, st_will_cmp, st_a_adr, st_b_adr, st_d_adr,
           st_bypass_b, st_ld, st_st, st_lock_ld, st_lock_wr, lsu_wb, ex_stall,
    input  sched_ack, iss_valid, iss_sel, iss_a_adr, iss_b_adr, iss_d_adr,
           iss_ld, iss_st
  );

  modport slave (
    input  st_alloc, st_ready, st_will_cmp, st_a_adr, st_b_adr, st_d_adr,
           st_bypass_b, st_ld, st_st, st_lock_ld, st_lock_wr, lsu_wb, ex_stall,
    output sched_ack, iss_valid, iss_sel, iss_a_adr, iss_b_adr, iss_d_adr,
           iss_ld, iss_st
  );

endinterface

// File: rtl/station_sched_age_matrix.sv
// -----------------------------------------------------------------------------
// sched_age_matrix
// Station valid bits plus a program-order age matrix, and an oldest-of-mask
// selector.
//
// Parameter: N_ST  number of stations
// Ports:
//   clk, a_rst   clock, asynchronous active-high reset
//   alloc[N]     station i receives a new micro-op (wins over clr)
//   clr[N]       station i leaves (granted and completing)
//   req[N]       candidate mask (eligible stations)
//   valid[N]     registered station valid bits
//   older[N][N]  older[i][j] = station i is older than station j
//   gnt[N]       one-hot: the requester with no older requester; lowest
//                index on ties
// -----------------------------------------------------------------------------
module sched_age_matrix #(
  parameter int N_ST = 4
) (
  input  logic                      clk,
  input  logic                      a_rst,
  input  logic [N_ST-1:0]           alloc,
  input  logic [N_ST-1:0]           clr,
  input  logic [N_ST-1:0]           req,
  output logic [N_ST-1:0]           valid,
  output logic [N_ST-1:0][N_ST-1:0] older,
  output logic [N_ST-1:0]           gnt
);

  logic [N_ST-1:0] cand;
  logic            found;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      valid <= '0;
      older <= '0;
    end else begin
      for (int i = 0; i < N_ST; i++) begin
        if (alloc[i])    valid[i] <= 1'b1;
        else if (clr[i]) valid[i] <= 1'b0;
      end
      // A newly allocated station is younger than every station already
      // resident. Stations allocated together get no mutual ordering, so
      // the lowest index wins between them.
      for (int i = 0; i < N_ST; i++) begin
        for (int j = 0; j < N_ST; j++) begin
          if (alloc[i])      older[i][j] <= 1'b0;
          else if (alloc[j]) older[i][j] <= (i != j) && valid[i];
        end
      end
    end
  end

  always_comb begin
    cand  = '0;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N_ST; i++) begin
      cand[i] = req[i];
      for (int j = 0; j < N_ST; j++) begin
        if ((j != i) && req[j] && older[j][i]) cand[i] = 1'b0;
      end
    end
    for (int i = 0; i < N_ST; i++) begin
      if (cand[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/station_sched.sv
// -----------------------------------------------------------------------------
// station_sched
// Issue scheduler for N_ST reservation stations sharing one ALU/AGU datapath
// and one LSU port. Each cycle it grants the oldest ready, hazard-free
// station (one-hot sched_ack, combinational) and registers that station's
// operand and control fields into the issue stage one cycle later.
// Hazards tracked: register write-back countdowns (scoreboard), older
// stations' register-write and load locks, and LSU occupancy.
//
// Parameters: N_ST (2..8) stations, WB_LAT (1..3) issue-to-write-back cycles
// Ports:
//   clk, a_rst   clock, asynchronous active-high reset
//   bus          station_sched_if.slave (station inputs, grant, issue stage)
//   perf_issue   16-bit saturating grant count        (STATION_SCHED_STATS_EN)
//   perf_stall   16-bit saturating no-grant-while-ready count
//                                                     (STATION_SCHED_STATS_EN)
// Build option: define STATION_SCHED_STATS_EN to add the two counters.
// -----------------------------------------------------------------------------
module station_sched
  import sched_pkg::*;
#(
  parameter int N_ST   = 4,
  parameter int WB_LAT = 2
) (
  input  logic           clk,
  input  logic           a_rst,
  station_sched_if.slave bus
`ifdef STATION_SCHED_STATS_EN
  ,
  output logic [15:0]    perf_issue,
  output logic [15:0]    perf_stall
`endif
);

  localparam int SEL_W = (N_ST > 1) ? $clog2(N_ST) : 1;

  logic [MAX_ST*REG_W-1:0]  a_ext;
  logic [MAX_ST*REG_W-1:0]  b_ext;
  logic [MAX_ST*DADR_W-1:0] d_ext;
  logic [MAX_ST*DADR_W-1:0] lw_ext;

  logic [N_ST-1:0]           st_valid;
  logic [N_ST-1:0]           eligible;
  logic [N_ST-1:0]           gnt;
  logic [N_ST-1:0][N_ST-1:0] older;

  logic [WB_CNT_W-1:0] sb_cnt [N_REGS];
  logic [N_REGS-1:0]   pending;
  logic                lsu_busy;

  logic               vld_p0;
  logic [SEL_W-1:0]   sel_idx_p0;
  logic [REG_W-1:0]   sel_a_p0;
  logic [REG_W-1:0]   sel_b_p0;
  logic [DADR_W-1:0]  sel_d_p0;
  logic               sel_ld_p0;
  logic               sel_st_p0;

  assign a_ext  = (MAX_ST*REG_W)'(bus.st_a_adr);
  assign b_ext  = (MAX_ST*REG_W)'(bus.st_b_adr);
  assign d_ext  = (MAX_ST*DADR_W)'(bus.st_d_adr);
  assign lw_ext = (MAX_ST*DADR_W)'(bus.st_lock_wr);

  sched_age_matrix #(.N_ST(N_ST)) u_age (
    .clk   (clk),
    .a_rst (a_rst),
    .alloc (bus.st_alloc),
    .clr   (gnt & bus.st_will_cmp),
    .req   (eligible),
    .valid (st_valid),
    .older (older),
    .gnt   (gnt)
  );

  always_comb begin
    pending = '0;
    for (int r = 0; r < N_REGS; r++) pending[r] = (sb_cnt[r] != '0);
  end

  // Stage p0: hazard screening and grant selection
  always_comb begin
    logic [REG_W-1:0]  a_i;
    logic [REG_W-1:0]  b_i;
    logic [DADR_W-1:0] d_i;
    logic [DADR_W-1:0] lw_j;
    logic              haz;
    a_i      = '0;
    b_i      = '0;
    d_i      = '0;
    lw_j     = '0;
    haz      = 1'b0;
    eligible = '0;
    for (int i = 0; i < N_ST; i++) begin
      a_i = reg_slice(a_ext, i);
      b_i = reg_slice(b_ext, i);
      d_i = dadr_slice(d_ext, i);
      haz = pending[a_i]
          | (~bus.st_bypass_b[i] & pending[b_i])
          | (d_i[DADR_WR_BIT] & pending[d_i[REG_W-1:0]])
          | (bus.st_ld[i] & lsu_busy);
      for (int j = 0; j < N_ST; j++) begin
        if ((j != i) && st_valid[j] && older[j][i]) begin
          lw_j = dadr_slice(lw_ext, j);
          // A bypassed B operand never reads the register file, so an
          // older lock on that register does not matter.
          if (lw_j[DADR_WR_BIT] &&
              ((lw_j[REG_W-1:0] == a_i) ||
               (!bus.st_bypass_b[i] && (lw_j[REG_W-1:0] == b_i))))
            haz = 1'b1;
          if (bus.st_ld[i] && bus.st_lock_ld[j]) haz = 1'b1;
        end
      end
      eligible[i] = st_valid[i] & bus.st_ready[i] & ~bus.ex_stall & ~haz;
    end
  end

  assign bus.sched_ack = gnt;
  assign vld_p0        = |gnt;

  always_comb begin
    sel_idx_p0 = '0;
    sel_a_p0   = '0;
    sel_b_p0   = '0;
    sel_d_p0   = '0;
    sel_ld_p0  = 1'b0;
    sel_st_p0  = 1'b0;
    for (int i = 0; i < N_ST; i++) begin
      if (gnt[i]) begin
        sel_idx_p0 = SEL_W'(i);
        sel_a_p0   = reg_slice(a_ext, i);
        sel_b_p0   = reg_slice(b_ext, i);
        sel_d_p0   = dadr_slice(d_ext, i);
        sel_ld_p0  = bus.st_ld[i];
        sel_st_p0  = bus.st_st[i];
      end
    end
  end

  // Scoreboard: a granted write restarts its register's countdown; the
  // eligibility screen guarantees that register was not already pending.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      for (int r = 0; r < N_REGS; r++) sb_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < N_REGS; r++) begin
        if (vld_p0 && sel_d_p0[DADR_WR_BIT] && (sel_d_p0[REG_W-1:0] == REG_W'(r)))
          sb_cnt[r] <= WB_CNT_W'(WB_LAT);
        else if (sb_cnt[r] != '0)
          sb_cnt[r] <= sb_cnt[r] - 1'b1;
      end
    end
  end

  // A load issued in the same cycle as a write-back keeps the LSU busy.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst)                  lsu_busy <= 1'b0;
    else if (vld_p0 && sel_ld_p0) lsu_busy <= 1'b1;
    else if (bus.lsu_wb)        lsu_busy <= 1'b0;
  end

  // Stage p1: issue register
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      bus.iss_valid <= 1'b0;
      bus.iss_sel   <= '0;
      bus.iss_a_adr <= '0;
      bus.iss_b_adr <= '0;
      bus.iss_d_adr <= '0;
      bus.iss_ld    <= 1'b0;
      bus.iss_st    <= 1'b0;
    end else begin
      bus.iss_valid <= vld_p0;
      if (vld_p0) begin
        bus.iss_sel   <= sel_idx_p0;
        bus.iss_a_adr <= sel_a_p0;
        bus.iss_b_adr <= sel_b_p0;
        bus.iss_d_adr <= sel_d_p0;
        bus.iss_ld    <= sel_ld_p0;
        bus.iss_st    <= sel_st_p0;
      end
    end
  end

`ifdef STATION_SCHED_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic stall_cyc_p0;
  assign stall_cyc_p0 = (|(st_valid & bus.st_ready)) & ~vld_p0;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (vld_p0)       perf_issue <= sat_inc(perf_issue);
      if (stall_cyc_p0) perf_stall <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_station_sched.sv
// -----------------------------------------------------------------------------
// tb_station_sched
// Self-checking bench for station_sched (N_ST = 4, WB_LAT = 2). A vector
// table covers program-order selection and ex_stall; hand-written sequences
// cover scoreboard countdown, lock bypass, LSU occupancy, mid-run reset and
// same-cycle alloc/complete. Expected issue-stage contents are queued when a
// grant is expected and compared when the issue register should show them.
// -----------------------------------------------------------------------------
module tb_station_sched;
  import sched_pkg::*;

  localparam int N = 4;

  logic clk;
  logic a_rst;

  station_sched_if #(.N_ST(N)) bus ();

`ifdef STATION_SCHED_STATS_EN
  logic [15:0] perf_issue;
  logic [15:0] perf_stall;
`endif

  station_sched #(.N_ST(N), .WB_LAT(2)) dut (
    .clk   (clk),
    .a_rst (a_rst),
    .bus   (bus)
`ifdef STATION_SCHED_STATS_EN
    ,
    .perf_issue (perf_issue),
    .perf_stall (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-station field shadows, packed onto the flattened buses.
  logic [2:0] sa  [N];
  logic [2:0] sb  [N];
  logic [3:0] sd  [N];
  logic [3:0] slw [N];
  logic       sbp [N];
  logic       sld [N];
  logic       sst [N];
  logic       slk [N];

  always_comb begin
    bus.st_a_adr    = '0;
    bus.st_b_adr    = '0;
    bus.st_d_adr    = '0;
    bus.st_lock_wr  = '0;
    bus.st_bypass_b = '0;
    bus.st_ld       = '0;
    bus.st_st       = '0;
    bus.st_lock_ld  = '0;
    for (int i = 0; i < N; i++) begin
      bus.st_a_adr[i*3 +: 3]   = sa[i];
      bus.st_b_adr[i*3 +: 3]   = sb[i];
      bus.st_d_adr[i*4 +: 4]   = sd[i];
      bus.st_lock_wr[i*4 +: 4] = slw[i];
      bus.st_bypass_b[i]       = sbp[i];
      bus.st_ld[i]             = sld[i];
      bus.st_st[i]             = sst[i];
      bus.st_lock_ld[i]        = slk[i];
    end
  end

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] d;
    logic       ld;
    logic       st;
  } iss_t;

  typedef struct packed {
    logic [3:0] alloc;
    logic [3:0] ready;
    logic [3:0] will;
    logic       stall;
    logic [3:0] exp_ack;
  } vec_t;

  iss_t  exp_q[$];
  vec_t  vt [14];
  int    checks;
  int    failures;
  int    exp_grants;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic iss_t shadow_iss(input logic [3:0] ack);
    iss_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        e.sel = 2'(i);
        e.a   = sa[i];
        e.b   = sb[i];
        e.d   = sd[i];
        e.ld  = sld[i];
        e.st  = sst[i];
      end
    end
    return e;
  endfunction

  function automatic iss_t dut_iss();
    iss_t g;
    g.sel = bus.iss_sel;
    g.a   = bus.iss_a_adr;
    g.b   = bus.iss_b_adr;
    g.d   = bus.iss_d_adr;
    g.ld  = bus.iss_ld;
    g.st  = bus.iss_st;
    return g;
  endfunction

  // Called just after an active edge with inputs already driven; checks
  // mid-cycle, then advances to just after the next edge.
  task automatic step(input logic [3:0] exp_ack, input string nm);
    iss_t e;
    #4;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({nm, ":iss_valid"}, 32'(bus.iss_valid), 32'd1);
      chk({nm, ":iss_fields"}, 32'(dut_iss()), 32'(e));
    end else begin
      chk({nm, ":iss_valid"}, 32'(bus.iss_valid), 32'd0);
    end
    chk({nm, ":ack"}, 32'(bus.sched_ack), 32'(exp_ack));
    if (exp_ack != 4'b0000) begin
      exp_q.push_back(shadow_iss(exp_ack));
      exp_grants++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] al, input logic [3:0] rd, input logic [3:0] wc,
                     input logic stl, input logic wb, input logic [3:0] exp_ack,
                     input string nm);
    bus.st_alloc    = al;
    bus.st_ready    = rd;
    bus.st_will_cmp = wc;
    bus.ex_stall    = stl;
    bus.lsu_wb      = wb;
    step(exp_ack, nm);
  endtask

  task automatic do_reset(input string nm);
    for (int i = 0; i < N; i++) begin
      sa[i] = '0; sb[i] = '0; sd[i] = '0; slw[i] = '0;
      sbp[i] = 1'b0; sld[i] = 1'b0; sst[i] = 1'b0; slk[i] = 1'b0;
    end
    bus.st_alloc    = '0;
    bus.st_ready    = '0;
    bus.st_will_cmp = '0;
    bus.ex_stall    = 1'b0;
    bus.lsu_wb      = 1'b0;
    a_rst = 1'b1;
    #2;
    chk({nm, ":rst_ack"}, 32'(bus.sched_ack), 32'd0);
    chk({nm, ":rst_iss"}, 32'({bus.iss_valid, dut_iss()}), 32'd0);
    exp_q.delete();
    exp_grants = 0;
    a_rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    exp_grants = 0;
    a_rst      = 1'b1;

    //           alloc    ready    will     stl   exp_ack
    vt[0]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    vt[1]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    vt[2]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    vt[3]  = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0100};
    vt[4]  = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0001};
    vt[5]  = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0010};
    vt[6]  = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0000};
    vt[7]  = '{4'b0111, 4'b0000, 4'b1111, 1'b0, 4'b0000};
    vt[8]  = '{4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b0000};
    vt[9]  = '{4'b0000, 4'b1111, 4'b1111, 1'b1, 4'b0000};
    vt[10] = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0001};
    vt[11] = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0010};
    vt[12] = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0100};
    vt[13] = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0000};

    // Program-order selection and ex_stall
    do_reset("V");
    for (int i = 0; i < N; i++) begin
      sa[i] = 3'(i + 1);
      sb[i] = 3'(6 - i);
      sd[i] = {1'b0, 3'(i)};
    end
    sst[1] = 1'b1;
    for (int k = 0; k < 14; k++)
      cyc(vt[k].alloc, vt[k].ready, vt[k].will, vt[k].stall, 1'b0, vt[k].exp_ack,
          $sformatf("V%0d", k));

    // Scoreboard: station 0 writes r3, station 1 reads r3
    do_reset("A");
    sd[0] = 4'b1011;
    sa[1] = 3'd3;
    cyc(4'b0001, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "A0");
    cyc(4'b0010, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "A1");
    cyc(4'b0000, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0001, "A2");
    cyc(4'b0000, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0000, "A3");
    cyc(4'b0000, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0000, "A4");
    cyc(4'b0000, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0010, "A5");
    cyc(4'b0000, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "A6");

    // Older write lock on r5 versus younger B read of r5
    do_reset("B");
    slw[0] = 4'b1101;
    sa[1]  = 3'd1;
    sb[1]  = 3'd5;
    sbp[1] = 1'b1;
    cyc(4'b0001, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "B0");
    cyc(4'b0010, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "B1");
    cyc(4'b0000, 4'b0010, 4'b0011, 1'b0, 1'b0, 4'b0010, "B2");
    cyc(4'b0000, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "B3");
    sbp[1] = 1'b0;
    cyc(4'b0010, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "B4");
    cyc(4'b0000, 4'b0010, 4'b0011, 1'b0, 1'b0, 4'b0000, "B5");
    cyc(4'b0000, 4'b0010, 4'b0011, 1'b0, 1'b0, 4'b0000, "B6");
    cyc(4'b0000, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0001, "B7");
    cyc(4'b0000, 4'b0010, 4'b0011, 1'b0, 1'b0, 4'b0010, "B8");
    cyc(4'b0000, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "B9");

    // LSU occupancy: four loads in age order 0,1,2,3
    do_reset("C");
    for (int i = 0; i < N; i++) sld[i] = 1'b1;
    cyc(4'b0001, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, "C0");
    cyc(4'b0010, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, "C1");
    cyc(4'b0100, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, "C2");
    cyc(4'b1000, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, "C3");
    cyc(4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, "C4");
    cyc(4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, "C5");
    cyc(4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, "C6");
    cyc(4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0010, "C7");
    cyc(4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, "C8");
    cyc(4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0100, "C9");
    cyc(4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000, "C10");
    cyc(4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, "C11");
    cyc(4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b1000, "C12");
    cyc(4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, "C13");

    // Reset in the middle of a scoreboard countdown
    do_reset("D");
    sd[0] = 4'b1011;
    sa[1] = 3'd3;
    cyc(4'b0001, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "D0");
    cyc(4'b0010, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "D1");
    cyc(4'b0000, 4'b0011, 4'b0011, 1'b0, 1'b0, 4'b0001, "D2");
    a_rst = 1'b1;
    #1;
    chk("D:midrst_ack", 32'(bus.sched_ack), 32'd0);
    chk("D:midrst_iss", 32'({bus.iss_valid, dut_iss()}), 32'd0);
    exp_q.delete();
    exp_grants = 0;
    a_rst = 1'b0;
    cyc(4'b0010, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "D3");
    cyc(4'b0000, 4'b0010, 4'b0011, 1'b0, 1'b0, 4'b0010, "D4");
    cyc(4'b0000, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'b0000, "D5");

    // Station 3 reallocated in the cycle it completes
    do_reset("E");
    sa[3] = 3'd2;
    sd[3] = 4'b0110;
    cyc(4'b1000, 4'b0000, 4'b1001, 1'b0, 1'b0, 4'b0000, "E0");
    cyc(4'b0001, 4'b0000, 4'b1001, 1'b0, 1'b0, 4'b0000, "E1");
    cyc(4'b1000, 4'b1001, 4'b1001, 1'b0, 1'b0, 4'b1000, "E2");
    cyc(4'b0000, 4'b1001, 4'b1001, 1'b0, 1'b0, 4'b0001, "E3");
    cyc(4'b0000, 4'b1001, 4'b1001, 1'b0, 1'b0, 4'b1000, "E4");
    cyc(4'b0000, 4'b0000, 4'b1001, 1'b0, 1'b0, 4'b0000, "E5");

`ifdef STATION_SCHED_STATS_EN
    chk("E:perf_issue", 32'(perf_issue), 32'(exp_grants));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
